// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave front end and the burst RAM.
// Master drives command words; slave returns read data and error pulses.
interface spi_ram_burst_if #(
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W+1:0] rx_data;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              cmd_err;

    modport master (
        output rx_valid, rx_data,
        input  tx_valid, tx_data, cmd_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output tx_valid, tx_data, cmd_err
    );
endinterface

// File: rtl/spi_ram_burst.sv
// SPI-attached RAM with auto-incrementing burst pointers and command checks.
// Read data 1 cycle after opcode 11; one command/cycle, no backpressure.
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_ram_burst_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic              addr_ok;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              wr_armed_q, wr_armed_d;
    logic              rd_armed_q, rd_armed_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              cmd_err_q, cmd_err_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign opcode  = bus.rx_data[DATA_W+1:DATA_W];
    assign payload = bus.rx_data[DATA_W-1:0];
    // Address must fit the array and leave no stray high payload bits.
    assign addr_ok = ({1'b0, payload[ADDR_W-1:0]} < DEPTH) && ((payload >> ADDR_W) == '0);

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;
        if (bus.rx_valid) begin
            case (opcode)
                2'b00: begin
                    if (addr_ok) begin
                        wr_ptr_d   = payload[ADDR_W-1:0];
                        wr_armed_d = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (wr_armed_q) begin
                        mem_we = 1'b1;
                        if (AUTO_INC != 0) wr_ptr_d = ptr_next(wr_ptr_q);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (addr_ok) begin
                        rd_ptr_d   = payload[ADDR_W-1:0];
                        rd_armed_d = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (rd_armed_q) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = mem[rd_ptr_q];
                        if (AUTO_INC != 0) rd_ptr_d = ptr_next(rd_ptr_q);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Array has no reset so contents survive rst_n; disarmed pointers block writes.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_armed_q <= 1'b0;
            rd_armed_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_armed_q <= wr_armed_d;
            rd_armed_q <= rd_armed_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst: three builds (default, depth 200,
// 16-bit static pointers) share one clock/reset and are driven one at a time.
module tb_spi_ram_burst;
    localparam int NONE = 0;
    localparam int DAT  = 1;
    localparam int ERR  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_burst_if #(.DATA_W(8))  ifa ();
    spi_ram_burst_if #(.DATA_W(8))  ifb ();
    spi_ram_burst_if #(.DATA_W(16)) ifc ();

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    spi_ram_burst #(.DATA_W(16), .ADDR_W(4), .MEM_DEPTH(16), .AUTO_INC(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    logic        tv [3];
    logic        te [3];
    logic [15:0] td [3];
    assign tv[0] = ifa.tx_valid;  assign te[0] = ifa.cmd_err;  assign td[0] = {8'h00, ifa.tx_data};
    assign tv[1] = ifb.tx_valid;  assign te[1] = ifb.cmd_err;  assign td[1] = {8'h00, ifb.tx_data};
    assign tv[2] = ifc.tx_valid;  assign te[2] = ifc.cmd_err;  assign td[2] = ifc.tx_data;

    typedef struct {
        int          id;
        int          cyc;
        bit          err;
        logic [15:0] d;
    } exp_t;

    exp_t        sb [$];
    exp_t        e_m;
    logic [15:0] last_rd [3];

    // Monitor: every output event must match the oldest expectation exactly,
    // including the cycle it appears in.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (tv[d] || te[d]) begin
                checks++;
                if (tv[d] && te[d]) begin
                    errors++;
                    $display("FAIL overlap dut%0d cyc=%0d: tx_valid and cmd_err both high", d, cyc);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected dut%0d cyc=%0d: got err=%0b data=%h, expected nothing",
                             d, cyc, te[d], td[d]);
                end else begin
                    e_m = sb.pop_front();
                    if (e_m.id != d || e_m.cyc != cyc || e_m.err != te[d] || e_m.d !== td[d]) begin
                        errors++;
                        $display("FAIL event dut%0d cyc=%0d err=%0b data=%h, expected dut%0d cyc=%0d err=%0b data=%h",
                                 d, cyc, te[d], td[d], e_m.id, e_m.cyc, e_m.err, e_m.d);
                    end
                end
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_m = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing dut%0d cyc=%0d: no output, expected err=%0b data=%h",
                     e_m.id, e_m.cyc, e_m.err, e_m.d);
        end
    end

    task automatic clr();
        ifa.rx_valid = 1'b0;  ifa.rx_data = '0;
        ifb.rx_valid = 1'b0;  ifb.rx_data = '0;
        ifc.rx_valid = 1'b0;  ifc.rx_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            clr();
        end
    endtask

    task automatic cmd(input int d, input logic [1:0] op, input logic [15:0] pay,
                       input int kind, input logic [15:0] ed);
        exp_t e;
        @(posedge clk);
        #1;
        clr();
        case (d)
            0: begin ifa.rx_valid = 1'b1; ifa.rx_data = {op, pay[7:0]}; end
            1: begin ifb.rx_valid = 1'b1; ifb.rx_data = {op, pay[7:0]}; end
            default: begin ifc.rx_valid = 1'b1; ifc.rx_data = {op, pay}; end
        endcase
        e.id  = d;
        e.cyc = cyc + 1;
        if (kind == DAT) begin
            e.err = 1'b0;
            e.d   = ed;
            last_rd[d] = ed;
            sb.push_back(e);
        end else if (kind == ERR) begin
            e.err = 1'b1;
            e.d   = last_rd[d];
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s tx_valid dut%0d", tag, d), {15'h0, tv[d]}, 16'h0);
            chk($sformatf("%s cmd_err dut%0d", tag, d), {15'h0, te[d]}, 16'h0);
            chk($sformatf("%s tx_data dut%0d", tag, d), td[d], 16'h0);
        end
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) last_rd[d] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        idle(2);

        // Read before any address load is rejected.
        cmd(0, 2'b11, 16'h00, ERR, 16'h0);
        // Three-word burst and back-to-back readback.
        cmd(0, 2'b00, 16'h10, NONE, 16'h0);
        cmd(0, 2'b01, 16'hA5, NONE, 16'h0);
        cmd(0, 2'b01, 16'h5A, NONE, 16'h0);
        cmd(0, 2'b01, 16'h3C, NONE, 16'h0);
        cmd(0, 2'b10, 16'h10, NONE, 16'h0);
        cmd(0, 2'b11, 16'h00, DAT, 16'hA5);
        cmd(0, 2'b11, 16'h00, DAT, 16'h5A);
        cmd(0, 2'b11, 16'h00, DAT, 16'h3C);
        // Pointer wrap from the top address to 0.
        cmd(0, 2'b00, 16'hFF, NONE, 16'h0);
        cmd(0, 2'b01, 16'h11, NONE, 16'h0);
        cmd(0, 2'b01, 16'h22, NONE, 16'h0);
        cmd(0, 2'b10, 16'hFF, NONE, 16'h0);
        cmd(0, 2'b11, 16'h00, DAT, 16'h11);
        cmd(0, 2'b11, 16'h00, DAT, 16'h22);
        // Write immediately followed by a read of the same address.
        cmd(0, 2'b10, 16'h40, NONE, 16'h0);
        cmd(0, 2'b00, 16'h40, NONE, 16'h0);
        cmd(0, 2'b01, 16'h66, NONE, 16'h0);
        cmd(0, 2'b11, 16'h00, DAT, 16'h66);
        idle(2);

        // Depth 200: 0xC8 is out of range, 0xC7 is the last word.
        cmd(1, 2'b00, 16'h05, NONE, 16'h0);
        cmd(1, 2'b00, 16'hC8, ERR, 16'h0);
        cmd(1, 2'b01, 16'h99, NONE, 16'h0);
        cmd(1, 2'b10, 16'h05, NONE, 16'h0);
        cmd(1, 2'b11, 16'h00, DAT, 16'h99);
        cmd(1, 2'b10, 16'hC8, ERR, 16'h0);
        cmd(1, 2'b00, 16'hC7, NONE, 16'h0);
        cmd(1, 2'b01, 16'hAA, NONE, 16'h0);
        cmd(1, 2'b01, 16'hBB, NONE, 16'h0);
        cmd(1, 2'b10, 16'hC7, NONE, 16'h0);
        cmd(1, 2'b11, 16'h00, DAT, 16'hAA);
        cmd(1, 2'b11, 16'h00, DAT, 16'hBB);
        idle(2);

        // Reset in the middle of a write burst.
        cmd(0, 2'b00, 16'h05, NONE, 16'h0);
        cmd(0, 2'b01, 16'h77, NONE, 16'h0);
        idle(2);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) last_rd[d] = 16'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset("midreset");
        rst_n = 1'b1;
        cmd(0, 2'b01, 16'h01, ERR, 16'h0);
        cmd(0, 2'b11, 16'h00, ERR, 16'h0);
        cmd(0, 2'b10, 16'h05, NONE, 16'h0);
        cmd(0, 2'b11, 16'h00, DAT, 16'h77);
        idle(2);

        // 16-bit words, 4-bit address, static pointers.
        cmd(2, 2'b00, 16'h0003, NONE, 16'h0);
        cmd(2, 2'b01, 16'hBEEF, NONE, 16'h0);
        cmd(2, 2'b01, 16'h1234, NONE, 16'h0);
        cmd(2, 2'b10, 16'h0003, NONE, 16'h0);
        cmd(2, 2'b11, 16'h0000, DAT, 16'h1234);
        cmd(2, 2'b11, 16'h0000, DAT, 16'h1234);
        cmd(2, 2'b00, 16'h0013, ERR, 16'h0);
        cmd(2, 2'b10, 16'h0010, ERR, 16'h0);
        cmd(2, 2'b01, 16'h5555, NONE, 16'h0);
        cmd(2, 2'b11, 16'h0000, DAT, 16'h5555);
        idle(4);

        while (sb.size() > 0) begin
            e_m = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL leftover dut%0d cyc=%0d: never seen, expected err=%0b data=%h",
                     e_m.id, e_m.cyc, e_m.err, e_m.d);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised successor to the single-port SPI-attached RAM. Sits behind the SPI slave and consumes its `rx_valid`/`rx_data` command words; returns read data on `tx_valid`/`tx_data`.
- Generalises data width, address width and depth.
- Adds burst auto-increment of the read and write pointers with wrap-around.
- Adds address-range and command-ordering checks, reported on `cmd_err`.

Parameters:
- DATA_W, 8: memory word width; `rx_data` is DATA_W+2 bits wide.
- ADDR_W, 8: address register width; must be <= DATA_W.
- MEM_DEPTH, 256: number of words; must be <= 2**ADDR_W.
- AUTO_INC, 1: 1 means each data access post-increments its pointer; 0 means pointers are static.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_valid  input  1  command word valid; qualifies `rx_data` for one cycle.
- rx_data  input  DATA_W+2  command word; [DATA_W+1:DATA_W] is the opcode, [DATA_W-1:0] is the payload.
- tx_valid  output  1  read data valid; single-cycle pulse.
- tx_data  output  DATA_W  read data word.
- cmd_err  output  1  single-cycle pulse when a command is rejected.

Behaviour:
- Reset (async assert, `rst_n` = 0):
  - `tx_valid` = 0, `tx_data` = 0, `cmd_err` = 0.
  - `wr_ptr` = 0, `rd_ptr` = 0, `wr_armed` = 0, `rd_armed` = 0.
  - Memory contents are NOT cleared; they survive reset.
  - Reset mid-burst abandons the burst; the next data command is rejected until an address is reloaded.
- Commands are processed only on cycles with `rx_valid` = 1: at most one command per cycle, acted on at that clock edge.
- Opcode 00, load write address:
  - If payload[ADDR_W-1:0] < MEM_DEPTH and payload[DATA_W-1:ADDR_W] == 0: `wr_ptr` <= payload, `wr_armed` <= 1.
  - Otherwise `cmd_err` pulses and `wr_ptr`/`wr_armed` are unchanged.
- Opcode 01, write data:
  - If `wr_armed`: mem[`wr_ptr`] <= payload. If AUTO_INC, `wr_ptr` <= (`wr_ptr` == MEM_DEPTH-1) ? 0 : `wr_ptr`+1.
  - If not armed: `cmd_err` pulses and there is no memory write.
- Opcode 10, load read address: same range check and error behaviour as opcode 00, acting on `rd_ptr`/`rd_armed`.
- Opcode 11, read data:
  - If `rd_armed`: on the next edge `tx_data` <= mem[`rd_ptr`] and `tx_valid` = 1 for exactly one cycle. If AUTO_INC, `rd_ptr` increments with the same wrap rule as `wr_ptr`.
  - If not armed: `cmd_err` pulses, `tx_valid` stays 0, `tx_data` holds.
- Latency: `tx_valid` rises 1 cycle after the opcode-11 `rx_valid` cycle. Back-to-back opcode-11 commands give back-to-back `tx_valid` pulses (throughput 1 word/cycle).
- `tx_data` holds its last read value when `tx_valid` = 0. `tx_valid` and `cmd_err` are never high together.
- Read-after-write ordering: a write accepted in cycle n followed by a read of the same address in cycle n+1 returns the new data. Memory is a registered-output array with write-first ordering.
- With AUTO_INC = 0, pointers change only via opcodes 00/10.
- `wr_armed`/`rd_armed` remain set until reset; reloading an address keeps them set.
- Every output is a register; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then opcode 11 with payload 0x00 -> `cmd_err` pulses 1 cycle, `tx_valid` stays 0, `tx_data` = 0x00.
- Opcode 00 payload 0x10; opcode 01 with 0xA5, 0x5A, 0x3C; opcode 10 payload 0x10; three opcode-11 commands back-to-back -> `tx_valid` high 3 consecutive cycles, `tx_data` = 0xA5, 0x5A, 0x3C.
- Wrap: opcode 00 payload 0xFF; write 0x11 then 0x22 -> mem[0xFF] = 0x11, mem[0x00] = 0x22. Read burst from 0xFF returns 0x11 then 0x22.
- Range: build with MEM_DEPTH = 200; opcode 00 payload 0xC8 -> `cmd_err` pulse, `wr_ptr` unchanged. A following opcode 01 writes at the prior `wr_ptr`.
- Reset mid-burst: after a write to address 0x05 with 0x77, assert `rst_n` low for 2 cycles, then opcode 01 -> `cmd_err`. Opcode 10 payload 0x05 plus opcode 11 -> `tx_data` = 0x77 (memory retained).
- AUTO_INC = 0, DATA_W = 16, ADDR_W = 4, MEM_DEPTH = 16: load write address 0x3, write 0xBEEF then 0x1234; read 0x3 twice -> 0x1234 both times.
